fsm_luces_monitor: RTL and testbench
====================================

// Module: fsm_luces_monitor
// PURPOSE
//  Receive-side checker for the 8-bit running-light bus LEDG driven by FSM_luces.
//  Watches LEDG and the shared ENABLE, locks onto the rotating one-hot pattern, and
//  reports the current LED position. Flags any deviation: wrong value, early step,
//  late step, or a step while disabled. Sits beside FSM_luces on the board top and in benches.
// PARAMETERS
//  PERIOD  25_000_000  enabled CLK cycles each LED is held (matches generator); >=1
//  CNT_W   $clog2(PERIOD+1)  dwell counter width (derived, do not override)
//  ERR_W   8           error counter width
// PORTS
//  CLK        in   1      system clock, all logic on rising edge
//  RSTn       in   1      synchronous active-low reset
//  ENABLE     in   1      same enable that drives FSM_luces; 0 = pattern frozen
//  LEDG       in   8      observed light bus
//  CLEAR      in   1      sync clear of ERR_STICKY/ERR_CNT
//  POS        out  3      index of lit LED while LOCKED (0 = LEDG[0])
//  LOCKED     out  1      1 while tracking a verified pattern
//  ERR_PULSE  out  1      1-cycle pulse per detected error
//  ERR_STICKY out  1      set on any error, held until CLEAR or reset
//  ERR_CNT    out  ERR_W  saturating error count
// BEHAVIOUR
//  Contract: LEDG is one-hot and rotates left (bit7 -> bit0) once every PERIOD enabled cycles.
//  - One clock; reset is synchronous and active-low: RSTn sampled low at a CLK rising edge
//    resets the block. Reset gives state=SYNC, dwell=0, prev=0, POS=0, LOCKED=0,
//    ERR_PULSE=0, ERR_STICKY=0, ERR_CNT=0. Reset mid-operation drops lock with no error.
//  - All outputs registered: a response to LEDG sampled at edge k is visible after edge k.
//  - States:
//    SYNC:   ENABLE=1 and LEDG one-hot -> prev<=LEDG. First sample with LEDG==rol(prev)
//            -> TRACK, dwell<=0, POS<=idx(LEDG), LOCKED<=1. Non-one-hot LEDG: prev<=0.
//            SYNC never raises errors.
//    TRACK:  ENABLE=1:
//              LEDG==prev and dwell<PERIOD-1  -> dwell++ (ok)
//              LEDG==rol(prev), dwell==PERIOD-1 -> prev<=LEDG, dwell<=0, POS<=POS+1 (wraps 7->0)
//              otherwise (early, late, non-one-hot, wrong bit) -> error
//            ENABLE=0: dwell frozen; LEDG!=prev -> error.
//  - Error: ERR_PULSE=1 for that cycle, ERR_STICKY<=1, ERR_CNT++ saturating at all-ones,
//    LOCKED<=0, state<=SYNC, prev<=LEDG if one-hot else 0, POS held.
//  - CLEAR: ERR_STICKY<=0, ERR_CNT<=0. On the same cycle as an error, the error wins:
//    STICKY=1, CNT=1.
//  - PERIOD=1: LEDG must rotate on every enabled cycle; dwell stays 0.
// STRUCTURE
//  - Shared header luces_defs.vh: LED_W=8, `ROL8(x) macro, state encodings SYNC/TRACK,
//    also used by FSM_luces.
//  - One sub-module: led_onehot_decode (comb) outputs valid + 3-bit index for 8-bit input.
//  - Top holds the 2-state FSM, dwell counter, prev register and error counters.
// TESTING  (PERIOD=4; generator model in the bench, or FSM_luces itself)
//  1. RSTn=0 for 2 cycles, then RSTn=1 with ENABLE=1 and clean pattern -> LOCKED=1 one cycle
//     after the first rotation is sampled; POS steps 0..7..0; ERR_STICKY stays 0.
//  2. LOCKED, LEDG forced 01->02 after 2 cycles instead of 4 -> ERR_PULSE one cycle,
//     ERR_CNT=1, LOCKED=0; relocks at the next legal rotation.
//  3. LOCKED, LEDG held 5 enabled cycles (late step) -> error on the 5th sample,
//     ERR_CNT increments.
//  4. ENABLE=0 for 10 cycles with LEDG frozen -> no error, POS held. With LEDG changed
//     while ENABLE=0 -> error.
//  5. LEDG=8'h03 or 8'h00 while LOCKED -> error. CLEAR asserted on the same cycle ->
//     ERR_STICKY=1, ERR_CNT=1. CLEAR alone later -> both return to 0.
//  6. ERR_W=2, inject 5 errors -> ERR_CNT saturates at 3. RSTn=0 mid-TRACK -> all outputs
//     are at reset values after the edge.

Source files
------------

// File: rtl/fsm_luces_monitor_pkg.sv
// Shared definitions for the running-light monitor: bus width, FSM states
// and the rotate-left helper that describes one legal step of the pattern.
package fsm_luces_monitor_pkg;

  localparam int LED_W = 8;
  localparam int IDX_W = 3;

  // SYNC: hunting for two consecutive legal values; TRACK: locked on.
  typedef enum logic {
    ST_SYNC  = 1'b0,
    ST_TRACK = 1'b1
  } luces_state_e;

  // One legal step of the pattern: bit7 wraps into bit0, every other bit moves up.
  function automatic logic [LED_W-1:0] rol8(input logic [LED_W-1:0] x);
    return {x[LED_W-2:0], x[LED_W-1]};
  endfunction

endpackage

// File: rtl/led_onehot_decode.sv
// Combinational one-hot decoder for the light bus: flags whether exactly one
// LED is lit and reports its index (index is only meaningful when valid).
module led_onehot_decode
  import fsm_luces_monitor_pkg::*;
(
  input  logic [LED_W-1:0] led_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [3:0] ones;

  // Count lit LEDs and remember the position of the highest lit one.
  always_comb begin
    ones  = 4'd0;
    idx_o = '0;
    for (int i = 0; i < LED_W; i++) begin
      if (led_i[i]) begin
        ones  = ones + 4'd1;
        idx_o = IDX_W'(i);
      end
    end
  end

  assign valid_o = (ones == 4'd1);

endmodule

// File: rtl/fsm_luces_monitor.sv
// Receive-side checker for the running-light bus. Locks onto the rotating
// one-hot pattern, reports the lit position, and flags wrong values, early or
// late steps, and changes while the shared enable is low.
module fsm_luces_monitor
  import fsm_luces_monitor_pkg::*;
#(
  parameter int PERIOD = 25_000_000,
  parameter int CNT_W  = $clog2(PERIOD + 1),
  parameter int ERR_W  = 8
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             ENABLE,
  input  logic [LED_W-1:0] LEDG,
  input  logic             CLEAR,
  output logic [IDX_W-1:0] POS,
  output logic             LOCKED,
  output logic             ERR_PULSE,
  output logic             ERR_STICKY,
  output logic [ERR_W-1:0] ERR_CNT,
  output luces_state_e     DBG_STATE
);

  // Last dwell count before a step is due; with PERIOD=1 this is 0 so the
  // pattern must move on every enabled cycle.
  localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(PERIOD - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  luces_state_e     state_q, state_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [LED_W-1:0] prev_q, prev_d;
  logic [IDX_W-1:0] pos_q, pos_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q;
  logic             err_d;
  logic             err_sticky_q, err_sticky_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic             led_valid;
  logic [IDX_W-1:0] led_idx;

  led_onehot_decode u_decode (
    .led_i   (LEDG),
    .valid_o (led_valid),
    .idx_o   (led_idx)
  );

  // Next-state logic: lock acquisition in SYNC, step/dwell checking in TRACK.
  always_comb begin
    state_d  = state_q;
    dwell_d  = dwell_q;
    prev_d   = prev_q;
    pos_d    = pos_q;
    locked_d = locked_q;
    err_d    = 1'b0;
    case (state_q)
      ST_SYNC: begin
        // While disabled the pattern is frozen, so there is nothing to learn.
        if (ENABLE) begin
          if (led_valid) begin
            prev_d = LEDG;
            // prev_q==0 rotates to 0, which never matches a one-hot value.
            if (LEDG == rol8(prev_q)) begin
              state_d  = ST_TRACK;
              dwell_d  = '0;
              pos_d    = led_idx;
              locked_d = 1'b1;
            end
          end else begin
            prev_d = '0;
          end
        end
      end
      ST_TRACK: begin
        if (ENABLE) begin
          if ((LEDG == prev_q) && (dwell_q < DWELL_MAX)) begin
            dwell_d = dwell_q + CNT_W'(1);
          end else if ((LEDG == rol8(prev_q)) && (dwell_q == DWELL_MAX)) begin
            prev_d  = LEDG;
            dwell_d = '0;
            pos_d   = pos_q + IDX_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end else if (LEDG != prev_q) begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_SYNC;
    endcase
    // Any deviation drops lock; keep the observed value as the new starting
    // point so relock can happen on the very next legal rotation.
    if (err_d) begin
      state_d  = ST_SYNC;
      locked_d = 1'b0;
      dwell_d  = '0;
      prev_d   = led_valid ? LEDG : '0;
    end
  end

  // Error bookkeeping: an error in the same cycle as CLEAR wins.
  always_comb begin
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;
    if (err_d) begin
      err_sticky_d = 1'b1;
      if (CLEAR) begin
        err_cnt_d = ERR_W'(1);
      end else if (err_cnt_q != ERR_MAX) begin
        err_cnt_d = err_cnt_q + ERR_W'(1);
      end
    end else if (CLEAR) begin
      err_sticky_d = 1'b0;
      err_cnt_d    = '0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q      <= ST_SYNC;
      dwell_q      <= '0;
      prev_q       <= '0;
      pos_q        <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      dwell_q      <= dwell_d;
      prev_q       <= prev_d;
      pos_q        <= pos_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign POS        = pos_q;
  assign LOCKED     = locked_q;
  assign ERR_PULSE  = err_pulse_q;
  assign ERR_STICKY = err_sticky_q;
  assign ERR_CNT    = err_cnt_q;
  assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_fsm_luces_monitor.sv
// Bench for fsm_luces_monitor: a running-light generator with injectable
// faults drives two monitors (8-bit and 2-bit error counters); an index-based
// reference model predicts every output after every edge.
module tb_fsm_luces_monitor;
  import fsm_luces_monitor_pkg::*;

  localparam int P = 4;

  localparam int F_NONE   = 0;
  localparam int F_EARLY  = 1;
  localparam int F_STALL  = 2;
  localparam int F_GLITCH = 3;
  localparam int F_03     = 4;
  localparam int F_00     = 5;

  logic       clk = 1'b0;
  logic       rstn, en, clr;
  logic [7:0] led;

  logic [2:0]   pos, pos2;
  logic         locked, pulse, sticky, locked2, pulse2, sticky2;
  logic [7:0]   cnt;
  logic [1:0]   cnt2;
  luces_state_e st, st2;

  int checks   = 0;
  int failures = 0;

  // reference model state (indices, not bit patterns)
  bit m_locked, m_pulse, m_sticky;
  int m_prev, m_held, m_pos, m_cnt, m_cnt2;

  // generator state
  int g_idx, g_cnt;

  fsm_luces_monitor #(.PERIOD(P), .ERR_W(8)) dut (
    .CLK(clk), .RSTn(rstn), .ENABLE(en), .LEDG(led), .CLEAR(clr),
    .POS(pos), .LOCKED(locked), .ERR_PULSE(pulse), .ERR_STICKY(sticky),
    .ERR_CNT(cnt), .DBG_STATE(st)
  );

  fsm_luces_monitor #(.PERIOD(P), .ERR_W(2)) dut_sat (
    .CLK(clk), .RSTn(rstn), .ENABLE(en), .LEDG(led), .CLEAR(clr),
    .POS(pos2), .LOCKED(locked2), .ERR_PULSE(pulse2), .ERR_STICKY(sticky2),
    .ERR_CNT(cnt2), .DBG_STATE(st2)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one call per rising edge with the sampled inputs.
  task automatic model_update();
    int  ones, li;
    bit  oh, err;
    if (!rstn) begin
      m_locked = 0; m_prev = -1; m_held = 0; m_pos = 0;
      m_pulse = 0; m_sticky = 0; m_cnt = 0; m_cnt2 = 0;
      return;
    end
    ones = 0; li = -1; err = 0;
    for (int i = 0; i < 8; i++) if (led[i]) begin ones++; li = i; end
    oh = (ones == 1);
    if (!m_locked) begin
      if (en) begin
        if (oh) begin
          if (m_prev >= 0 && li == (m_prev + 1) % 8) begin
            m_locked = 1; m_pos = li; m_held = 0;
          end
          m_prev = li;
        end else begin
          m_prev = -1;
        end
      end
    end else if (en) begin
      if (oh && li == m_prev && m_held < P - 1) m_held++;
      else if (oh && li == (m_prev + 1) % 8 && m_held == P - 1) begin
        m_prev = li; m_held = 0; m_pos = (m_pos + 1) % 8;
      end else err = 1;
    end else begin
      if (!(oh && li == m_prev)) err = 1;
    end
    if (err) begin
      m_locked = 0; m_held = 0;
      m_prev = oh ? li : -1;
    end
    m_pulse = err;
    if (err) begin
      m_sticky = 1;
      m_cnt  = clr ? 1 : ((m_cnt  < 255) ? m_cnt  + 1 : 255);
      m_cnt2 = clr ? 1 : ((m_cnt2 < 3)   ? m_cnt2 + 1 : 3);
    end else if (clr) begin
      m_sticky = 0; m_cnt = 0; m_cnt2 = 0;
    end
  endtask

  task automatic compare_all();
    check("pos",     32'(pos),     32'(m_pos));
    check("locked",  32'(locked),  32'(m_locked));
    check("pulse",   32'(pulse),   32'(m_pulse));
    check("sticky",  32'(sticky),  32'(m_sticky));
    check("cnt",     32'(cnt),     32'(m_cnt));
    check("state",   32'(st),      32'(m_locked));
    check("pos2",    32'(pos2),    32'(m_pos));
    check("locked2", 32'(locked2), 32'(m_locked));
    check("pulse2",  32'(pulse2),  32'(m_pulse));
    check("sticky2", 32'(sticky2), 32'(m_sticky));
    check("cnt2",    32'(cnt2),    32'(m_cnt2));
    check("state2",  32'(st2),     32'(m_locked));
  endtask

  // One clock edge: model consumes the sampled inputs, outputs checked 1 ns later.
  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  // Drive one generator sample (optionally faulted) and advance one edge.
  task automatic gen_step(input bit e, input int fault);
    logic [7:0] v;
    en = e;
    if (fault == F_EARLY) begin
      g_idx = (g_idx + 1) % 8;
      g_cnt = 0;
    end
    v = 8'h01 << g_idx;
    case (fault)
      F_GLITCH: v = 8'($urandom);
      F_03:     v = 8'h03;
      F_00:     v = 8'h00;
      default:  ;
    endcase
    led = v;
    cycle();
    if (e && fault != F_STALL) begin
      g_cnt++;
      if (g_cnt == P) begin
        g_cnt = 0;
        g_idx = (g_idx + 1) % 8;
      end
    end
    clr = 1'b0;
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) gen_step(1'b1, F_NONE);
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; clr = 1'b0; led = 8'h00;
    m_prev = -1;
    g_idx = 0; g_cnt = 0;

    // reset held for two edges
    cycle();
    cycle();
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_cnt",    32'(cnt),    32'd0);

    // clean pattern: lock after the first rotation (5th sample), then POS walks 0..7..0
    rstn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      gen_step(1'b1, F_NONE);
      check("p1_lock", 32'(locked), (i >= 4) ? 32'd1 : 32'd0);
    end
    check("p1_sticky", 32'(sticky), 32'd0);

    // early step, then relock
    gen_step(1'b1, F_EARLY);
    clean(12);
    // late step (extra hold), then relock
    gen_step(1'b1, F_STALL);
    clean(12);

    // disabled with frozen bus: no error, POS held
    for (int i = 0; i < 10; i++) begin
      gen_step(1'b0, F_NONE);
      check("dis_pulse", 32'(pulse), 32'd0);
    end
    // bus changes while disabled
    gen_step(1'b0, F_EARLY);
    check("dis_err", 32'(pulse), 32'd1);
    clean(12);

    // invalid value with CLEAR in the same cycle: error wins
    clr = 1'b1;
    gen_step(1'b1, F_03);
    check("clr_sticky", 32'(sticky), 32'd1);
    check("clr_cnt",    32'(cnt),    32'd1);
    clean(10);
    gen_step(1'b1, F_00);
    clean(10);
    clr = 1'b1;
    gen_step(1'b1, F_NONE);
    check("clr2_sticky", 32'(sticky), 32'd0);
    check("clr2_cnt",    32'(cnt),    32'd0);

    // five locked errors: narrow counter saturates
    clean(10);
    for (int k = 0; k < 5; k++) begin
      gen_step(1'b1, F_03);
      clean(10);
    end
    check("sat_cnt",  32'(cnt),  32'd5);
    check("sat_cnt2", 32'(cnt2), 32'd3);

    // reset mid-TRACK
    rstn = 1'b0;
    gen_step(1'b1, F_NONE);
    check("mrst_locked", 32'(locked), 32'd0);
    check("mrst_sticky", 32'(sticky), 32'd0);
    check("mrst_pos",    32'(pos),    32'd0);
    rstn = 1'b1;
    clean(12);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int f;
      bit e;
      rstn = ($urandom_range(0, 999) != 0);
      clr  = ($urandom_range(0, 39) == 0);
      e    = ($urandom_range(0, 9) != 0);
      f    = ($urandom_range(0, 29) == 0) ? int'($urandom_range(1, 5)) : F_NONE;
      gen_step(e, f);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
